// File: rtl/switch_debouncer_if.sv
// rtl/switch_debouncer_if.sv - raw switch input and conditioned outputs of switch_debouncer
interface switch_debouncer_if #(
  parameter int PCNT_W = 8
);
  logic              raw_in;
  logic              db_out;
  logic              rise_pulse;
  logic              fall_pulse;
  logic              toggle_q;
  logic [PCNT_W-1:0] press_count;

  modport master (
    input  raw_in,
    output db_out, rise_pulse, fall_pulse, toggle_q, press_count
  );

  modport slave (
    output raw_in,
    input  db_out, rise_pulse, fall_pulse, toggle_q, press_count
  );
endinterface

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - 2-flop synchronizer plus counter-based debounce FSM with edge pulses,
// press toggle and wrapping press counter; every output comes straight from a flop.
module switch_debouncer #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int PCNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  switch_debouncer_if.master   bus
);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam bit ONE_CYCLE = (STABLE_CYCLES == 1);

  typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} state_t;

  state_t            state;
  logic              sync1, sync_s;
  logic [CNT_W-1:0]  cnt;
  logic              db_q, rise_q, fall_q, tog_q;
  logic [PCNT_W-1:0] pcnt_q;
  logic              go_hi, go_lo;

  // cnt holds how many deviating samples have been seen, including the one that
  // left the stable state, so acceptance lands exactly STABLE_CYCLES samples in.
  always_comb begin
    go_hi = 1'b0;
    go_lo = 1'b0;
    case (state)
      STABLE_LO: go_hi = sync_s && ONE_CYCLE;
      CHK_HI:    go_hi = sync_s && (cnt == CNT_LAST);
      STABLE_HI: go_lo = !sync_s && ONE_CYCLE;
      CHK_LO:    go_lo = !sync_s && (cnt == CNT_LAST);
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync_s <= 1'b0;
      state  <= STABLE_LO;
      cnt    <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      tog_q  <= 1'b0;
      pcnt_q <= '0;
    end else begin
      sync1  <= bus.raw_in;
      sync_s <= sync1;
      rise_q <= go_hi;
      fall_q <= go_lo;
      if (go_hi) begin
        state  <= STABLE_HI;
        cnt    <= '0;
        db_q   <= 1'b1;
        tog_q  <= ~tog_q;
        pcnt_q <= pcnt_q + 1'b1;
      end else if (go_lo) begin
        state <= STABLE_LO;
        cnt   <= '0;
        db_q  <= 1'b0;
      end else begin
        case (state)
          STABLE_LO: if (sync_s) begin
            state <= CHK_HI;
            cnt   <= CNT_W'(1);
          end
          CHK_HI: if (!sync_s) begin
            state <= STABLE_LO;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
          STABLE_HI: if (!sync_s) begin
            state <= CHK_LO;
            cnt   <= CNT_W'(1);
          end
          CHK_LO: if (sync_s) begin
            state <= STABLE_HI;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
          default: state <= STABLE_LO;
        endcase
      end
    end
  end

  assign bus.db_out      = db_q;
  assign bus.rise_pulse  = rise_q;
  assign bus.fall_pulse  = fall_q;
  assign bus.toggle_q    = tog_q;
  assign bus.press_count = pcnt_q;
endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - randomized and directed bench for switch_debouncer
// (STABLE_CYCLES 4 and 1 instances driven with the same raw input).
module tb_switch_debouncer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  switch_debouncer_if #(.PCNT_W(8)) bus4 ();
  switch_debouncer_if #(.PCNT_W(8)) bus1 ();

  switch_debouncer #(.STABLE_CYCLES(4), .PCNT_W(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  switch_debouncer #(.STABLE_CYCLES(1), .PCNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: level accepted once the synchronized input has differed from it
  // for STABLE_CYCLES consecutive samples; sync input = raw_in two edges earlier.
  logic       raw_q[$];
  logic       m_acc[2], m_rise[2], m_fall[2], m_tog[2];
  logic [7:0] m_cnt[2];
  int         m_run[2];
  int         m_sc[2] = '{4, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    raw_q.delete();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 1'b0; m_rise[i] = 1'b0; m_fall[i] = 1'b0;
      m_tog[i] = 1'b0; m_cnt[i] = 8'd0; m_run[i] = 0;
    end
  endtask

  task automatic model_edge(input logic r);
    logic smp;
    smp = (raw_q.size() == 2) ? raw_q[0] : 1'b0;
    raw_q.push_back(r);
    if (raw_q.size() > 2) void'(raw_q.pop_front());
    for (int i = 0; i < 2; i++) begin
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      if (smp != m_acc[i]) begin
        m_run[i]++;
        if (m_run[i] == m_sc[i]) begin
          m_acc[i] = smp;
          m_run[i] = 0;
          if (smp) begin
            m_rise[i] = 1'b1;
            m_tog[i]  = ~m_tog[i];
            m_cnt[i]  = m_cnt[i] + 8'd1;
          end else begin
            m_fall[i] = 1'b1;
          end
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  function automatic logic [31:0] exp_vec(input int i);
    return 32'({m_acc[i], m_rise[i], m_fall[i], m_tog[i], m_cnt[i]});
  endfunction

  function automatic logic [31:0] obs4();
    return 32'({bus4.db_out, bus4.rise_pulse, bus4.fall_pulse, bus4.toggle_q, bus4.press_count});
  endfunction

  function automatic logic [31:0] obs1();
    return 32'({bus1.db_out, bus1.rise_pulse, bus1.fall_pulse, bus1.toggle_q, bus1.press_count});
  endfunction

  task automatic tick(input logic r);
    bus4.raw_in = r;
    bus1.raw_in = r;
    @(posedge clk);
    model_edge(r);
    @(negedge clk);
    check("sc4_outputs", obs4(), exp_vec(0));
    check("sc1_outputs", obs1(), exp_vec(1));
  endtask

  task automatic ticks(input logic r, input int n);
    for (int k = 0; k < n; k++) tick(r);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic lvl;
    rst = 1'b1;
    bus4.raw_in = 1'b0;
    bus1.raw_in = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_sc4", obs4(), 32'd0);
    check("reset_sc1", obs1(), 32'd0);
    rst = 1'b0;

    // press held: accepted on the 6th edge
    ticks(1'b1, 5);
    check("t1_db_before", 32'(bus4.db_out), 32'd0);
    tick(1'b1);
    check("t1_db_after", 32'(bus4.db_out), 32'd1);
    check("t1_rise", 32'(bus4.rise_pulse), 32'd1);
    check("t1_toggle", 32'(bus4.toggle_q), 32'd1);
    check("t1_count", 32'(bus4.press_count), 32'd1);
    tick(1'b1);
    check("t1_rise_end", 32'(bus4.rise_pulse), 32'd0);

    // release, then a 3-sample bounce that must be rejected, then a clean press
    ticks(1'b0, 6);
    ticks(1'b1, 3);
    ticks(1'b0, 6);
    check("t2_bounce_db", 32'(bus4.db_out), 32'd0);
    check("t2_bounce_count", 32'(bus4.press_count), 32'd1);
    ticks(1'b1, 6);
    check("t2_clean_db", 32'(bus4.db_out), 32'd1);
    check("t2_clean_count", 32'(bus4.press_count), 32'd2);

    // release from high
    ticks(1'b0, 5);
    check("t3_db_before", 32'(bus4.db_out), 32'd1);
    tick(1'b0);
    check("t3_db_after", 32'(bus4.db_out), 32'd0);
    check("t3_fall", 32'(bus4.fall_pulse), 32'd1);
    check("t3_count", 32'(bus4.press_count), 32'd2);
    check("t3_toggle", 32'(bus4.toggle_q), 32'd0);
    tick(1'b0);
    check("t3_fall_end", 32'(bus4.fall_pulse), 32'd0);

    // 256 presses wrap the counter
    apply_reset();
    for (int p = 1; p <= 256; p++) begin
      ticks(1'b1, 6);
      ticks(1'b0, 6);
      if (p == 255) check("t4_count_255", 32'(bus4.press_count), 32'd255);
    end
    check("t4_count_wrap", 32'(bus4.press_count), 32'd0);
    check("t4_toggle", 32'(bus4.toggle_q), 32'd0);

    // async reset mid-check, raw held high through release
    ticks(1'b1, 6);
    ticks(1'b0, 6);
    ticks(1'b1, 4);
    #2 rst = 1'b1;
    #1;
    check("t5_async_sc4", obs4(), 32'd0);
    check("t5_async_sc1", obs1(), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    ticks(1'b1, 5);
    check("t5_db_before", 32'(bus4.db_out), 32'd0);
    tick(1'b1);
    check("t5_db_after", 32'(bus4.db_out), 32'd1);
    check("t5_rise", 32'(bus4.rise_pulse), 32'd1);
    tick(1'b1);
    check("t5_rise_end", 32'(bus4.rise_pulse), 32'd0);

    // single-cycle pulse accepted by the STABLE_CYCLES=1 instance only
    apply_reset();
    ticks(1'b0, 3);
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    check("t6_db_high", 32'(bus1.db_out), 32'd1);
    check("t6_rise", 32'(bus1.rise_pulse), 32'd1);
    tick(1'b0);
    check("t6_db_low", 32'(bus1.db_out), 32'd0);
    check("t6_fall", 32'(bus1.fall_pulse), 32'd1);
    check("t6_sc4_ignores", 32'(bus4.press_count), 32'd0);
    tick(1'b0);

    // random bouncy runs against the model
    lvl = 1'b0;
    for (int k = 0; k < 120; k++) begin
      lvl = ~lvl;
      ticks(lvl, $urandom_range(1, 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
